// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that borrows the shared execute-stage ALU for each add.
// Optional early termination when the multiplier runs out of set bits: EARLY_TERM_EN.
module alu_mul_sequencer #(
  parameter int          WIDTH     = 32,
  parameter logic [3:0]  ADD_CODE  = 4'b0010,
  parameter logic [3:0]  IDLE_CODE = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             busy,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_a1,
  output logic [WIDTH-1:0] alu_a2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0] m, m_nx;
  logic [WIDTH-1:0] q, q_nx;
  logic [CW-1:0]    count, count_nx;
  logic             q_empty;

`ifdef EARLY_TERM_EN
  assign q_empty = (q == '0);
`else
  assign q_empty = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      m     <= '0;
      q     <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      m     <= m_nx;
      q     <= q_nx;
      count <= count_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    acc_nx     = acc;
    m_nx       = m;
    q_nx       = q;
    count_nx   = count;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_result = '0;
    out_zero   = 1'b0;
    busy       = 1'b0;
    alu_req    = 1'b0;
    alu_a1     = '0;
    alu_a2     = '0;
    alu_ctrl   = IDLE_CODE;
    unique case (state)
      IDLE: begin
        // ready stays low while reset is held, even though state is IDLE
        in_ready = rst_n;
        if (in_valid) begin
          m_nx     = in_a;
          q_nx     = in_b;
          acc_nx   = '0;
          count_nx = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (q_empty) begin
          state_nx = DONE;
        end else begin
          alu_req  = 1'b1;
          alu_a1   = acc;
          alu_a2   = m;
          alu_ctrl = ADD_CODE;
          if (alu_gnt) begin
            if (q[0]) acc_nx = alu_out;
            m_nx     = m << 1;
            q_nx     = q >> 1;
            count_nx = count + CW'(1);
            if (count_nx == CW'(WIDTH)) state_nx = DONE;
          end
        end
      end
      DONE: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        out_result = acc;
        out_zero   = (acc == '0);
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized bench for alu_mul_sequencer with an arithmetic reference model.
// Build with +define+EARLY_TERM_EN to exercise early termination.
module tb_alu_mul_sequencer;

  localparam int         W    = 32;
  localparam logic [3:0] ADDC = 4'b0010;
  localparam logic [3:0] IDLC = 4'b0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic         busy;
  logic         alu_req;
  logic         alu_gnt;
  logic [W-1:0] alu_a1;
  logic [W-1:0] alu_a2;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_out;

  int errors = 0;
  int checks = 0;
  int gnt_mode = 0;

  alu_mul_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .busy(busy), .alu_req(alu_req), .alu_gnt(alu_gnt),
    .alu_a1(alu_a1), .alu_a2(alu_a2),
    .alu_ctrl(alu_ctrl), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  // shared ALU: ADD or AND depending on control
  assign alu_out = (alu_ctrl == ADDC) ? alu_a1 + alu_a2
                                      : alu_a1 & alu_a2;

  task automatic chk(input string name,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // reference model: phase 0 idle, 1 run, 2 done; k = granted steps
  int           ph = 0;
  int           k = 0;
  int           denied = 0;
  logic [W-1:0] ma = '0;
  logic [W-1:0] mb = '0;

  function automatic bit et_now();
`ifdef EARLY_TERM_EN
    return (mb >> k) == '0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] prod();
    logic [63:0] t;
    t = {32'd0, ma} * {32'd0, mb};
    return t[W-1:0];
  endfunction

  // accumulator after k steps = a * (low k bits of b)
  function automatic logic [W-1:0] acc_at(int n);
    logic [63:0] msk;
    logic [63:0] t;
    msk = (n >= W) ? 64'hFFFF_FFFF : ((64'd1 << n) - 64'd1);
    t = {32'd0, ma} * ({32'd0, mb} & msk);
    return t[W-1:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0;
      k  = 0;
    end else begin
      case (ph)
        0: if (in_valid) begin
          ma = in_a; mb = in_b;
          k = 0; denied = 0; ph = 1;
        end
        1: begin
          if (et_now()) ph = 2;
          else if (alu_gnt) begin
            k++;
            if (k == W) ph = 2;
          end else denied++;
        end
        default: if (out_ready) ph = 0;
      endcase
    end
  end

  function automatic logic [104:0] exp_vec();
    logic [W-1:0] p;
    logic [W-1:0] sh;
    if (!rst_n)
      return {5'b00000, IDLC, 96'd0};
    case (ph)
      0: return {5'b10000, IDLC, 96'd0};
      1: begin
        if (et_now()) return {5'b00010, IDLC, 96'd0};
        sh = ma << k;
        return {5'b00011, ADDC, acc_at(k), sh, 32'd0};
      end
      default: begin
        p = prod();
        return {2'b01, (p == '0), 2'b10, IDLC, 64'd0, p};
      end
    endcase
  endfunction

  function automatic logic [104:0] got_vec();
    return {in_ready, out_valid, out_zero, busy, alu_req,
            alu_ctrl, alu_a1, alu_a2, out_result};
  endfunction

  always @(negedge clk) chk("cycle", 128'(got_vec()), 128'(exp_vec()));

  always @(negedge clk) begin
    #2;
    case (gnt_mode)
      0: alu_gnt = 1'b1;
      1: alu_gnt = ~alu_gnt;
      default: alu_gnt = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold,
                        output logic [W-1:0] res, output int lat,
                        output int expl);
    int n;
    bit got;
    int steps;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 128'(in_ready), 128'(1));
    #2;
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom;
    lat = 0; got = 1'b0;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1'b1;
    end
    chk("done_wait", 128'(got), 128'(1));
`ifdef EARLY_TERM_EN
    steps = 0;
    for (int i = 0; i < W; i++) if (b[i]) steps = i + 1;
    expl = steps + ((steps == W) ? 0 : 1) + denied + 1;
`else
    steps = W;
    expl = steps + 1 + denied;
`endif
    res = out_result;
    for (int h = 0; h < hold; h++) begin
      #2;
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    #2;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_done", 128'(in_ready), 128'(1));
  endtask

  task automatic directed(input string name,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] want, input int mode,
                          input int hold);
    logic [W-1:0] r;
    int lat;
    int expl;
    gnt_mode = mode;
    run_op(a, b, hold, r, lat, expl);
    chk(name, 128'(r), 128'(want));
    chk({name, "_lat"}, 128'(lat), 128'(expl));
  endtask

  initial begin
    logic [W-1:0] r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [63:0]  p;
    int lat;
    int expl;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = '0;
    in_b = '0;
    alu_gnt = 1'b1;
    #1;
    chk("reset", 128'(got_vec()), 128'({5'b00000, IDLC, 96'd0}));
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;

    gnt_mode = 0;
    run_op(32'd6, 32'd7, 0, r, lat, expl);
    chk("mul_6x7", 128'(r), 128'(32'h2A));
`ifdef EARLY_TERM_EN
    chk("lat_6x7", 128'(lat), 128'(5));
`else
    chk("lat_6x7", 128'(lat), 128'(33));
`endif
    directed("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 0, 0);
    directed("msb_x2", 32'h8000_0000, 32'd2, 32'h0, 0, 0);
    directed("zero_a", 32'h0, 32'h1234_5678, 32'h0, 0, 0);
    directed("x_one", 32'h1234_5678, 32'd1, 32'h1234_5678, 0, 0);
    directed("alt_gnt", 32'h1A, 32'h15, 32'h222, 1, 5);

    // async reset in the middle of RUN
    gnt_mode = 0;
    @(negedge clk);
    #2;
    in_a = 32'hDEAD_BEEF; in_b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_before_rst", 128'(busy), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 128'(got_vec()), 128'({5'b00000, IDLC, 96'd0}));
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    directed("after_rst", 32'd3, 32'd5, 32'hF, 0, 0);

`ifdef EARLY_TERM_EN
    gnt_mode = 0;
    run_op(32'd3, 32'd2, 0, r, lat, expl);
    chk("et_3x2", 128'(r), 128'(32'd6));
    chk("et_lat", 128'(lat), 128'(4));
`endif

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i % 7 == 0) b = '0;
      p = {32'd0, a} * {32'd0, b};
      run_op(a, b, $urandom_range(0, 3), r, lat, expl);
      chk("rand_res", 128'(r), 128'(p[W-1:0]));
      chk("rand_lat", 128'(lat), 128'(expl));
      if (i == 0) gnt_mode = 2;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
